// File: rtl/pong_pkg.sv
// Shared geometry, state encoding and helpers for the Pong frame sequencer.
package pong_pkg;

  typedef logic [11:0] coord_t;

  localparam coord_t SCREEN_W    = 12'd640;
  localparam coord_t SCREEN_H    = 12'd480;
  localparam coord_t PADDLE_W    = 12'd10;
  localparam coord_t PADDLE_H    = 12'd80;
  localparam coord_t PADDLE_X1   = 12'd16;
  localparam coord_t PADDLE_X2   = 12'd614;
  localparam coord_t BALL_SIZE   = 12'd8;
  localparam coord_t BALL_STEP   = 12'd2;

  // Paddle arithmetic runs 11-bit signed so stepping past 0 cannot wrap.
  localparam logic signed [10:0] PADDLE_STEP_S = 11'sd4;
  localparam logic signed [10:0] PADDLE_YMAX_S = 11'sd400;
  localparam logic [9:0]         PADDLE_YMAX   = 10'd400;
  localparam logic [9:0]         PADDLE_Y0     = 10'd200;

  localparam logic [9:0] BALL_CX     = 10'd316;
  localparam logic [9:0] BALL_CY     = 10'd236;
  localparam logic [9:0] BALL_YMAX   = 10'd472;
  localparam logic [9:0] LEFT_HIT_X  = 10'd26;
  localparam logic [9:0] RIGHT_HIT_X = 10'd606;

  localparam logic [5:0] POINT_LAST = 6'd59;
  localparam logic [3:0] WIN_SCORE  = 4'd9;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  function automatic coord_t ext10(input logic [9:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    if (s >= WIN_SCORE) begin
      return WIN_SCORE;
    end else begin
      return s + 4'd1;
    end
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: steps its top y on a frame tick from level buttons, clamped to
// the screen, held while frozen.
module pong_paddle_ctrl
  import pong_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       freeze_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [9:0] y_o
);

  logic [9:0]        y_q, y_d;
  logic signed [10:0] cur_s, up_s, dn_s;

  // Next paddle position: clamp to [0, SCREEN_H - PADDLE_H].
  always_comb begin
    y_d   = y_q;
    cur_s = $signed({1'b0, y_q});
    up_s  = cur_s - PADDLE_STEP_S;
    dn_s  = cur_s + PADDLE_STEP_S;
    if (tick_i && !freeze_i) begin
      if (up_i && !down_i) begin
        y_d = (up_s < 11'sd0) ? 10'd0 : up_s[9:0];
      end else if (down_i && !up_i) begin
        y_d = (dn_s > PADDLE_YMAX_S) ? PADDLE_YMAX : dn_s[9:0];
      end else begin
        y_d = y_q;
      end
    end else begin
      y_d = y_q;
    end
  end

  // Paddle register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      y_q <= PADDLE_Y0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: steps paddles, ball, scores and the game state once per
// video frame (falling edge of V_visible).
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       V_visible,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       serve,
  output logic [9:0] p1_paddle_y,
  output logic [9:0] p2_paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic [1:0] state_dbg
);

  state_e     state_q, state_d;
  logic       vv_q;
  logic [9:0] bx_q, bx_d, by_q, by_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic [5:0] cnt_q, cnt_d;
  logic       game_over_q;
  logic       frame_tick_s, freeze_s, ov1_s, ov2_s;
  logic [9:0] p1_y_s, p2_y_s;
  coord_t     x_w, y_w, nx_w, ny_w, p1_w, p2_w;

  assign frame_tick_s = vv_q & ~V_visible;
  assign freeze_s     = (state_q == ST_OVER);

  pong_paddle_ctrl u_paddle_p1 (
    .clk_i    (CLOCK_50),
    .rst_ni   (rst_n),
    .tick_i   (frame_tick_s),
    .freeze_i (freeze_s),
    .up_i     (p1_up),
    .down_i   (p1_down),
    .y_o      (p1_y_s)
  );

  pong_paddle_ctrl u_paddle_p2 (
    .clk_i    (CLOCK_50),
    .rst_ni   (rst_n),
    .tick_i   (frame_tick_s),
    .freeze_i (freeze_s),
    .up_i     (p2_up),
    .down_i   (p2_down),
    .y_o      (p2_y_s)
  );

  // Game FSM and ball motion; collisions use the pre-tick paddle positions.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    cnt_d   = cnt_q;
    x_w     = ext10(bx_q);
    y_w     = ext10(by_q);
    p1_w    = ext10(p1_y_s);
    p2_w    = ext10(p2_y_s);
    nx_w    = dx_q ? (x_w + BALL_STEP) : (x_w - BALL_STEP);
    ny_w    = dy_q ? (y_w + BALL_STEP) : (y_w - BALL_STEP);
    ov1_s   = (y_w + BALL_SIZE > p1_w) && (y_w < p1_w + PADDLE_H);
    ov2_s   = (y_w + BALL_SIZE > p2_w) && (y_w < p2_w + PADDLE_H);
    if (frame_tick_s) begin
      case (state_q)
        ST_SERVE: begin
          bx_d = BALL_CX;
          by_d = BALL_CY;
          if (serve) state_d = ST_PLAY;
          else       state_d = ST_SERVE;
        end
        ST_PLAY: begin
          if (!dy_q && (y_w < BALL_STEP)) begin
            by_d = 10'd0;
            dy_d = 1'b1;
          end else if (dy_q && (y_w + BALL_SIZE + BALL_STEP > SCREEN_H)) begin
            by_d = BALL_YMAX;
            dy_d = 1'b0;
          end else begin
            by_d = ny_w[9:0];
          end
          // A paddle hit wins over a miss; a miss recentres and scores.
          if (!dx_q) begin
            if ((x_w >= PADDLE_X1 + PADDLE_W) && (nx_w < PADDLE_X1 + PADDLE_W) && ov1_s) begin
              bx_d = LEFT_HIT_X;
              dx_d = 1'b1;
            end else if (x_w < BALL_STEP) begin
              s2_d    = sat_inc(s2_q);
              bx_d    = BALL_CX;
              by_d    = BALL_CY;
              dx_d    = 1'b0;
              state_d = ST_POINT;
            end else begin
              bx_d = nx_w[9:0];
            end
          end else begin
            if ((x_w + BALL_SIZE <= PADDLE_X2) && (nx_w + BALL_SIZE > PADDLE_X2) && ov2_s) begin
              bx_d = RIGHT_HIT_X;
              dx_d = 1'b0;
            end else if (x_w + BALL_SIZE + BALL_STEP > SCREEN_W) begin
              s1_d    = sat_inc(s1_q);
              bx_d    = BALL_CX;
              by_d    = BALL_CY;
              dx_d    = 1'b1;
              state_d = ST_POINT;
            end else begin
              bx_d = nx_w[9:0];
            end
          end
        end
        ST_POINT: begin
          bx_d = BALL_CX;
          by_d = BALL_CY;
          if (cnt_q == POINT_LAST) begin
            cnt_d = 6'd0;
            if ((s1_q == WIN_SCORE) || (s2_q == WIN_SCORE)) state_d = ST_OVER;
            else                                            state_d = ST_SERVE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        ST_OVER: begin
          if (serve) begin
            s1_d    = 4'd0;
            s2_d    = 4'd0;
            bx_d    = BALL_CX;
            by_d    = BALL_CY;
            state_d = ST_SERVE;
          end else begin
            state_d = ST_OVER;
          end
        end
        default: begin
          state_d = ST_SERVE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers; reset wins over everything, including a coincident tick.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      vv_q        <= 1'b0;
      state_q     <= ST_SERVE;
      bx_q        <= BALL_CX;
      by_q        <= BALL_CY;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      s1_q        <= 4'd0;
      s2_q        <= 4'd0;
      cnt_q       <= 6'd0;
      game_over_q <= 1'b0;
    end else begin
      vv_q        <= V_visible;
      state_q     <= state_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cnt_q       <= cnt_d;
      game_over_q <= (state_d == ST_OVER);
    end
  end

  assign p1_paddle_y = p1_y_s;
  assign p2_paddle_y = p2_y_s;
  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign score_p1    = s1_q;
  assign score_p2    = s2_q;
  assign game_over   = game_over_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: the driver steps a game model per frame
// and queues the expected outputs; the monitor compares at every frame/reset.
module tb_pong_game_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n = 1'b1, V_visible = 1'b0;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0, serve = 1'b0;
  logic [9:0] p1_paddle_y, p2_paddle_y, ball_x, ball_y;
  logic [3:0] score_p1, score_p2;
  logic       game_over;
  logic [1:0] state_dbg;

  pong_game_ctrl dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .V_visible(V_visible),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .serve(serve), .p1_paddle_y(p1_paddle_y), .p2_paddle_y(p2_paddle_y),
    .ball_x(ball_x), .ball_y(ball_y), .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct { int p1y, p2y, bx, by, s1, s2, go, st; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0;

  // Game model: plain integers, direction as +1/-1, state as 0..3.
  int m_p1y, m_p2y, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_st, m_cnt;
  int hits_l = 0, hits_r = 0, bottom_bounces = 0, points = 0;

  function automatic int step_paddle(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
    if (dn && !up) return (y + 4 > 400) ? 400 : y + 4;
    return y;
  endfunction

  function automatic bit overlaps(input int by, input int py);
    return (by + 8 > py) && (by < py + 80);
  endfunction

  task automatic model_reset();
    m_p1y = 200; m_p2y = 200; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0;
  endtask

  task automatic model_tick(input bit u1, d1, u2, d2, srv);
    int old1, old2, nx, ny, ndx, ndy;
    old1 = m_p1y; old2 = m_p2y;
    if (m_st != 3) begin
      m_p1y = step_paddle(m_p1y, u1, d1);
      m_p2y = step_paddle(m_p2y, u2, d2);
    end
    case (m_st)
      0: if (srv) m_st = 1;
      1: begin
        nx = m_bx + 2 * m_dx; ny = m_by + 2 * m_dy; ndx = m_dx; ndy = m_dy;
        if (m_dy < 0 && m_by < 2) begin ny = 0; ndy = 1; end
        else if (m_dy > 0 && m_by + 10 > 480) begin ny = 472; ndy = -1; bottom_bounces++; end
        if (m_dx < 0) begin
          if (m_bx >= 26 && nx < 26 && overlaps(m_by, old1)) begin nx = 26; ndx = 1; hits_l++; end
          else if (m_bx < 2) begin
            m_s2 = (m_s2 >= 9) ? 9 : m_s2 + 1; nx = 316; ny = 236; ndx = -1; m_st = 2; points++;
          end
        end else begin
          if (m_bx + 8 <= 614 && nx + 8 > 614 && overlaps(m_by, old2)) begin nx = 606; ndx = -1; hits_r++; end
          else if (m_bx + 10 > 640) begin
            m_s1 = (m_s1 >= 9) ? 9 : m_s1 + 1; nx = 316; ny = 236; ndx = 1; m_st = 2; points++;
          end
        end
        m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
      end
      2: begin
        if (m_cnt == 59) begin
          m_cnt = 0; m_st = (m_s1 == 9 || m_s2 == 9) ? 3 : 0;
        end else m_cnt++;
      end
      default: if (srv) begin m_s1 = 0; m_s2 = 0; m_bx = 316; m_by = 236; m_st = 0; end
    endcase
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.p1y = m_p1y; e.p2y = m_p2y; e.bx = m_bx; e.by = m_by;
    e.s1 = m_s1; e.s2 = m_s2; e.go = (m_st == 3) ? 1 : 0; e.st = m_st;
    return e;
  endfunction

  task automatic check_out(input exp_t e, input string tag);
    n_checks++;
    if (p1_paddle_y !== 10'(e.p1y) || p2_paddle_y !== 10'(e.p2y) || ball_x !== 10'(e.bx) ||
        ball_y !== 10'(e.by) || score_p1 !== 4'(e.s1) || score_p2 !== 4'(e.s2) ||
        game_over !== 1'(e.go) || state_dbg !== 2'(e.st)) begin
      n_fail++;
      $display("FAIL %s @%0t: got p1y=%0d p2y=%0d ball=(%0d,%0d) sc=%0d/%0d go=%0d st=%0d, expected p1y=%0d p2y=%0d ball=(%0d,%0d) sc=%0d/%0d go=%0d st=%0d",
               tag, $time, p1_paddle_y, p2_paddle_y, ball_x, ball_y, score_p1, score_p2, game_over, state_dbg,
               e.p1y, e.p2y, e.bx, e.by, e.s1, e.s2, e.go, e.st);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Monitor: an output update is due on a reset edge or a V_visible falling edge;
  // on every other edge the outputs must hold the last expected snapshot.
  initial begin : monitor
    exp_t e, last;
    bit have_last, hist, ev;
    have_last = 1'b0; hist = 1'b0;
    forever begin
      @(posedge CLOCK_50);
      ev   = !rst_n || (hist && !V_visible);
      hist = rst_n ? V_visible : 1'b0;
      #1;
      if (ev) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_update @%0t: DUT update edge with no queued expectation", $time);
        end else begin
          e = exp_q.pop_front();
          check_out(e, rst_n ? "frame" : "reset");
          last = e; have_last = 1'b1;
        end
      end else if (have_last) begin
        check_out(last, "hold");
      end
    end
  end

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLOCK_50);
      rst_n = 1'b0; V_visible = 1'b0;
      model_reset();
      exp_q.push_back(snap());
    end
    @(negedge CLOCK_50);
    rst_n = 1'b1;
  endtask

  task automatic frame(input bit u1, d1, u2, d2, srv);
    @(negedge CLOCK_50);
    p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2; serve = srv;
    V_visible = 1'b1;
    repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    V_visible = 1'b0;
    model_tick(u1, d1, u2, d2, srv);
    exp_q.push_back(snap());
    repeat ($urandom_range(1, 3)) @(negedge CLOCK_50);
  endtask

  // Steering helpers: dodge keeps the paddle on the far half from the ball,
  // track centres the paddle on the ball.
  function automatic bit [1:0] dodge(input int py);
    return (m_by + 4 < 240) ? 2'b01 : 2'b10;
  endfunction

  function automatic bit [1:0] track(input int py);
    if (m_by + 4 < py + 36) return 2'b10;
    if (m_by + 4 > py + 44) return 2'b01;
    return 2'b00;
  endfunction

  initial begin : driver
    bit [1:0] a, b;
    do_reset(2);
    repeat (3) frame(0, 0, 0, 0, 0);
    repeat (60) frame(1, 0, 0, 0, 0);
    check_val("p1_at_top", int'(p1_paddle_y), 0);
    repeat (5) frame(1, 1, 0, 0, 0);
    frame(0, 0, 0, 0, 1);
    repeat (300) frame(0, 0, 0, 0, 0);
    check_val("bottom_bounce_seen", int'(bottom_bounces > 0), 1);
    check_val("first_point_p1", int'(score_p1), 1);
    for (int f = 0; f < 4000 && m_st != 3; f++) begin
      a = dodge(m_p1y); b = dodge(m_p2y);
      frame(a[1], a[0], b[1], b[0], m_st == 0);
    end
    check_val("game_over_reached", int'(game_over), 1);
    check_val("winner_score", int'(score_p1), 9);
    frame(0, 0, 0, 0, 1);
    check_val("restart_state", int'(state_dbg), 0);
    check_val("restart_score", int'(score_p1), 0);
    for (int f = 0; f < 1500; f++) begin
      a = track(m_p1y); b = track(m_p2y);
      frame(a[1], a[0], b[1], b[0], m_st == 0 || m_st == 3);
    end
    check_val("left_hit_seen", int'(hits_l > 0), 1);
    check_val("right_hit_seen", int'(hits_r > 0), 1);
    for (int f = 0; f < 600; f++) begin
      frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
    end
    while (m_st != 1) frame(0, 0, 0, 0, 1);
    repeat (20) frame(1, 0, 0, 1, 0);
    // Reset lands on the edge that would otherwise have been a frame tick.
    @(negedge CLOCK_50);
    V_visible = 1'b1; p1_down = 1'b1; serve = 1'b1;
    @(negedge CLOCK_50);
    do_reset(1);
    check_val("reset_ball_x", int'(ball_x), 316);
    check_val("reset_state", int'(state_dbg), 0);
    repeat (3) frame(0, 0, 0, 0, 0);
    repeat (4) @(negedge CLOCK_50);
    check_val("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Frame-rate game sequencer for the Pong display. It owns the paddle and ball positions and the scores, and steps them once per video frame. Its outputs drive the box-drawing logic in the VGA top level: the paddle and ball x/y locations, plus the score and status signals. The frame tick comes from the VGA driver's V_visible.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
PADDLE_W, 10, paddle width
PADDLE_H, 80, paddle height
PADDLE_X1, 16, left paddle x (fixed)
PADDLE_X2, 614, right paddle x (fixed)
BALL_SIZE, 8, ball edge length
PADDLE_STEP, 4, paddle pixels per frame
BALL_STEP, 2, ball pixels per frame per axis
POINT_PAUSE, 60, frames held after a point
WIN_SCORE, 9, score that ends the game

Ports:
CLOCK_50  in  1  system clock, 50 MHz
rst_n  in  1  synchronous active-low reset
V_visible  in  1  vertical-visible flag from the VGA driver
p1_up, p1_down  in  1 each  player-1 buttons, level
p2_up, p2_down  in  1 each  player-2 buttons, level
serve  in  1  serve/restart button, level
p1_paddle_y  out  10  left paddle top y
p2_paddle_y  out  10  right paddle top y
ball_x, ball_y  out  10 each  ball top-left corner
score_p1, score_p2  out  4 each  scores
game_over  out  1  high in OVER
state_dbg  out  2  current state encoding

Behaviour:
- One clock (CLOCK_50). Reset is synchronous and active-low on rst_n; it is sampled only at a CLOCK_50 edge. Reset overrides every other input in the same cycle.
- Reset values:
  - p1_paddle_y = p2_paddle_y = 200.
  - ball = (316, 236); direction dx = +, dy = +.
  - scores = 0, game_over = 0, state = SERVE, pause counter = 0.
  - V_visible history register = 0.
- frame_tick: one-cycle pulse when the registered V_visible = 1 and the current V_visible = 0 (start of vertical blank). All state and position updates happen only on a CLOCK_50 edge where frame_tick = 1. Outputs change 1 cycle after the tick; otherwise they hold.
- Buttons and serve are level-sampled at frame_tick; no debounce.
- Paddles (all states except OVER):
  - up only: y = max(0, y - PADDLE_STEP).
  - down only: y = min(SCREEN_H - PADDLE_H, y + PADDLE_STEP).
  - both or neither: hold.
  - Intermediate arithmetic is 11-bit signed, so no wrap-around.
- States:
  - SERVE (0): ball held at centre. If serve = 1 -> PLAY.
  - PLAY (1): ball update as below.
  - POINT (2): ball held at centre; counter increments per tick. When the counter reaches POINT_PAUSE - 1: clear the counter, then go to OVER if either score = WIN_SCORE, else SERVE.
  - OVER (3): game_over = 1; paddles frozen. If serve = 1: scores = 0, ball recentred, go to SERVE.
- Ball update in PLAY:
  - Collision checks use the pre-tick paddle positions. nx = x ± BALL_STEP, ny = y ± BALL_STEP.
  - Y walls:
    - dy = - and y < BALL_STEP: y = 0, dy = +.
    - dy = + and y + BALL_SIZE + BALL_STEP > SCREEN_H: y = SCREEN_H - BALL_SIZE, dy = -.
    - Otherwise y = ny.
  - Vertical overlap with paddle P: ball_y + BALL_SIZE > P_y and ball_y < P_y + PADDLE_H.
  - Left side (dx = -):
    - Hit: x >= PADDLE_X1 + PADDLE_W, nx < PADDLE_X1 + PADDLE_W, and overlap with p1. Then x = PADDLE_X1 + PADDLE_W, dx = +.
    - Miss: otherwise, if x < BALL_STEP: score_p2 += 1, ball to centre, dx = - (toward the loser), go to POINT.
  - Right side (dx = +):
    - Hit: x + BALL_SIZE <= PADDLE_X2, nx + BALL_SIZE > PADDLE_X2, and overlap with p2. Then x = PADDLE_X2 - BALL_SIZE, dx = -.
    - Miss: otherwise, if x + BALL_SIZE + BALL_STEP > SCREEN_W: score_p1 += 1, ball to centre, dx = +, go to POINT.
  - Otherwise x = nx.
  - A paddle hit has priority over a miss. X and Y resolve independently in the same tick (corner bounce allowed).
  - Scores saturate at WIN_SCORE.
- Reset mid-game: all values return to reset state on the next edge, regardless of state or frame_tick.

Decomposition:
- pong_pkg holds:
  - screen and paddle geometry constants;
  - state encoding SERVE = 0, PLAY = 1, POINT = 2, OVER = 3;
  - the centre-position constants.
- Sub-module pong_paddle_ctrl (instanced twice): inputs up, down, tick, freeze; output a clamped y.

Test Plan:
- Reset, then 3 frames with no input -> p1_y = p2_y = 200, ball (316, 236), state_dbg = 0, scores 0.
- Hold p1_up for 60 frames -> p1_y falls by 4 per frame, reaches 0 at frame 50, stays 0. p1_up and p1_down together -> y holds.
- serve for 1 frame, then no paddle input -> ball moves +2/+2 per frame and bounces off the bottom at y = 472 with dy flipping. frame_tick is exactly 1 cycle per V_visible falling edge.
- Park p2 at y = 0 and let the ball reach the right edge -> score_p1 = 1, state POINT, ball centred. After 60 frames -> SERVE. The next serve sends the ball with dx = +.
- Place p1 overlapping the ball's path -> ball x clamps to 26 and dx flips to +; score unchanged.
- Drive score_p1 to 9 -> after the pause, OVER and game_over = 1. serve -> scores 0, SERVE. rst_n = 0 mid-PLAY -> all reset values on the next edge.
